// File: rtl/hpc_share_codec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hpc_share_codec_pkg
//  Description : Shared defaults, rnd_in field offsets and the share-slice
//                index helper for the masked AND codec.
//  Revision    : 1.0 - initial release
// ============================================================================
package hpc_share_codec_pkg;

  // Default geometry: 8-bit lanes, 3 shares (order 2), 2-cycle gadget,
  // 4-entry return FIFO.
  localparam int unsigned C_W_DEFAULT     = 8;
  localparam int unsigned C_N_DEFAULT     = 3;
  localparam int unsigned C_LAT_DEFAULT   = 2;
  localparam int unsigned C_DEPTH_DEFAULT = 4;

  // rnd_in field offsets, in units of W bits.
  localparam int unsigned C_RND_M0_SLOT     = 0;  // operand a, share 1
  localparam int unsigned C_RND_M1_SLOT     = 1;  // operand a, share 2
  localparam int unsigned C_RND_M2_SLOT     = 2;  // operand b, share 1
  localparam int unsigned C_RND_M3_SLOT     = 3;  // operand b, share 2
  localparam int unsigned C_RND_GADGET_SLOT = 4;  // first gadget slice
  localparam int unsigned C_RND_SLOTS       = 10; // total rnd_in width / W
  localparam int unsigned C_GADGET_SLOTS    = 6;  // enc_rand width / W

  // Low bit index of share k inside a packed N*W share vector.
  function automatic int unsigned share_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/share_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : share_fifo
//  Description : Return FIFO holding still-masked result shares. Pointers wrap
//                modulo DEPTH, so DEPTH need not be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module share_fifo #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en;
  logic              rd_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // Pointer and occupancy update; push+pop together leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
    if (rd_en) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage write; contents need no reset because count gates visibility.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = push_data;
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage register.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
    else $error("share_fifo: push into full FIFO");

endmodule
`default_nettype wire

// File: rtl/hpc_share_codec.sv
`default_nettype none
// ============================================================================
//  Module      : hpc_share_codec
//  Description : Masks two operands into 3-share encodings for an external
//                HPC AND gadget, tracks gadget latency with a token shift
//                register, buffers the returned shares in a FIFO and unmasks
//                the FIFO head on the way out.
//  Revision    : 1.0 - initial release
// ============================================================================
module hpc_share_codec
  import hpc_share_codec_pkg::*;
#(
  parameter int unsigned W     = C_W_DEFAULT,
  parameter int unsigned N     = C_N_DEFAULT,     // encoder is built for 3 shares
  parameter int unsigned LAT   = C_LAT_DEFAULT,   // >= 1
  parameter int unsigned DEPTH = C_DEPTH_DEFAULT  // >= LAT+1
) (
  input  logic                           clock_0,
  input  logic                           reset_0,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [W-1:0]                   in_a,
  input  logic [W-1:0]                   in_b,
  input  logic [C_RND_SLOTS*W-1:0]       rnd_in,
  input  logic                           rnd_valid,
  output logic [N*W-1:0]                 enc_a,
  output logic [N*W-1:0]                 enc_b,
  output logic [C_GADGET_SLOTS*W-1:0]    enc_rand,
  output logic                           enc_valid,
  input  logic [N*W-1:0]                 ret_z,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [W-1:0]                   out_z
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned OCC_W = $clog2(DEPTH+LAT+1) + 1;

  logic [N*W-1:0]              enc_a_q,    enc_a_d;
  logic [N*W-1:0]              enc_b_q,    enc_b_d;
  logic [C_GADGET_SLOTS*W-1:0] enc_rand_q, enc_rand_d;
  logic [LAT-1:0]              token_q,    token_d;

  logic [W-1:0]     mask0, mask1, mask2, mask3;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [N*W-1:0]   fifo_head;
  logic [OCC_W-1:0] occupancy;
  logic [W-1:0]     unmasked;

  assign mask0 = rnd_in[C_RND_M0_SLOT*W +: W];
  assign mask1 = rnd_in[C_RND_M1_SLOT*W +: W];
  assign mask2 = rnd_in[C_RND_M2_SLOT*W +: W];
  assign mask3 = rnd_in[C_RND_M3_SLOT*W +: W];

  // Accepted-but-not-yet-buffered operations plus FIFO entries bound the
  // return traffic, so the FIFO can never overflow.
  always_comb begin
    occupancy = OCC_W'(fifo_count);
    for (int i = 0; i < LAT; i++) begin
      occupancy = occupancy + OCC_W'(token_q[i]);
    end
  end

  assign in_ready = ~reset_0 & (occupancy < OCC_W'(DEPTH));
  assign accept   = in_valid & rnd_valid & in_ready;

  // Token shift: bit 0 is the enc_valid pulse, bit LAT-1 marks the cycle in
  // which the gadget presents the matching result shares.
  always_comb begin
    token_d    = token_q;
    token_d[0] = accept;
    for (int i = 1; i < LAT; i++) begin
      token_d[i] = token_q[i-1];
    end
  end

  // Share encoding: the operand is only ever XORed with masks before it is
  // stored, so no register holds it in the clear. Registers hold when idle.
  always_comb begin
    enc_a_d    = enc_a_q;
    enc_b_d    = enc_b_q;
    enc_rand_d = enc_rand_q;
    if (accept) begin
      enc_a_d[share_lo(0, W) +: W] = (in_a ^ mask0) ^ mask1;
      enc_a_d[share_lo(1, W) +: W] = mask0;
      enc_a_d[share_lo(2, W) +: W] = mask1;
      enc_b_d[share_lo(0, W) +: W] = (in_b ^ mask2) ^ mask3;
      enc_b_d[share_lo(1, W) +: W] = mask2;
      enc_b_d[share_lo(2, W) +: W] = mask3;
      enc_rand_d = rnd_in[C_RND_SLOTS*W-1 : C_RND_GADGET_SLOT*W];
    end
  end

  // Encoding and token registers; reset also drops anything in flight.
  always_ff @(posedge clock_0 or posedge reset_0) begin
    if (reset_0) begin
      enc_a_q    <= '0;
      enc_b_q    <= '0;
      enc_rand_q <= '0;
      token_q    <= '0;
    end else begin
      enc_a_q    <= enc_a_d;
      enc_b_q    <= enc_b_d;
      enc_rand_q <= enc_rand_d;
      token_q    <= token_d;
    end
  end

  assign enc_a     = enc_a_q;
  assign enc_b     = enc_b_q;
  assign enc_rand  = enc_rand_q;
  assign enc_valid = token_q[0];

  assign push      = token_q[LAT-1];
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  share_fifo #(
    .DATA_W (N*W),
    .DEPTH  (DEPTH)
  ) u_ret_fifo (
    .clk       (clock_0),
    .rst       (reset_0),
    .push      (push),
    .push_data (ret_z),
    .pop       (pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Unmask only at the output boundary; an empty FIFO reads as zero.
  always_comb begin
    unmasked = '0;
    for (int k = 0; k < N; k++) begin
      unmasked = unmasked ^ fifo_head[share_lo(k, W) +: W];
    end
    out_z = out_valid ? unmasked : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_hpc_share_codec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hpc_share_codec
//  Description : Self-checking bench for hpc_share_codec with a behavioural
//                2-cycle masked AND gadget and a queue-based result model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hpc_share_codec;

  localparam int W     = 8;
  localparam int N     = 3;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clock_0 = 1'b0;
  logic          reset_0;
  logic          in_valid, in_ready, rnd_valid;
  logic [7:0]    in_a, in_b;
  logic [79:0]   rnd_in;
  logic [23:0]   enc_a, enc_b, ret_z;
  logic [47:0]   enc_rand;
  logic          enc_valid, out_valid, out_ready;
  logic [7:0]    out_z;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  hpc_share_codec #(.W(W), .N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock_0  (clock_0),
    .reset_0  (reset_0),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .rnd_in   (rnd_in),
    .rnd_valid(rnd_valid),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .enc_rand (enc_rand),
    .enc_valid(enc_valid),
    .ret_z    (ret_z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_z    (out_z)
  );

  always #5 clock_0 = ~clock_0;

  // Behavioural gadget: the codec's encoding register is its first stage,
  // one more register here gives a total latency of LAT = 2.
  function automatic logic [23:0] gadget(input logic [23:0] sa, input logic [23:0] sb,
                                         input logic [47:0] r);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] z;
    a = sa[7:0] ^ sa[15:8] ^ sa[23:16];
    b = sb[7:0] ^ sb[15:8] ^ sb[23:16];
    z = a & b;
    return {r[15:8], r[7:0], z ^ r[7:0] ^ r[15:8]};
  endfunction

  logic [23:0] gad_q;
  always @(posedge clock_0) gad_q <= gadget(enc_a, enc_b, enc_rand);
  assign ret_z = gad_q;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [79:0] rand_rnd();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[79:0];
  endfunction

  // Reference model: results queue with the cycle at which each becomes visible.
  typedef struct { logic [7:0] z; int rdy; } exp_t;
  exp_t        q[$];
  logic        exp_enc_valid;
  logic [23:0] exp_enc_a, exp_enc_b;
  logic [47:0] exp_enc_rand;

  task automatic model_reset();
    q.delete();
    exp_enc_valid = 1'b0;
    exp_enc_a     = '0;
    exp_enc_b     = '0;
    exp_enc_rand  = '0;
  endtask

  // One clock cycle: drive, check the current outputs against the model,
  // advance the model, then step past the edge.
  task automatic cycle(input bit iv, input bit rv, input bit ordy,
                       input logic [7:0] a, input logic [7:0] b, input logic [79:0] rnd);
    bit          exp_ir, exp_ov, acc;
    logic [23:0] na, nb;
    logic [47:0] nr;
    in_valid = iv; rnd_valid = rv; out_ready = ordy;
    in_a = a; in_b = b; rnd_in = rnd;
    exp_ir = (q.size() < DEPTH);
    exp_ov = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("enc_valid", enc_valid, exp_enc_valid);
    chk("enc_a", enc_a, exp_enc_a);
    chk("enc_b", enc_b, exp_enc_b);
    chk("enc_rand", enc_rand, exp_enc_rand);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) chk("out_z", out_z, q[0].z);
    if (exp_ov && ordy) void'(q.pop_front());
    acc = iv && rv && exp_ir;
    na = exp_enc_a; nb = exp_enc_b; nr = exp_enc_rand;
    if (acc) begin
      q.push_back('{z: a & b, rdy: cyc + 1 + LAT});
      na = {rnd[15:8],  rnd[7:0],   a ^ rnd[7:0]   ^ rnd[15:8]};
      nb = {rnd[31:24], rnd[23:16], b ^ rnd[23:16] ^ rnd[31:24]};
      nr = rnd[79:32];
    end
    @(posedge clock_0);
    cyc++;
    #1;
    exp_enc_valid = acc;
    exp_enc_a = na; exp_enc_b = nb; exp_enc_rand = nr;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(0, 0, ordy, 8'h00, 8'h00, 80'h0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [79:0] rnd;
    logic [23:0] ea;
    logic [23:0] eb;
    logic [7:0]  z;
  } vec_t;
  vec_t vt [4];

  initial begin
    reset_0 = 1'b1; in_valid = 0; rnd_valid = 0; out_ready = 0;
    in_a = '0; in_b = '0; rnd_in = '0;
    model_reset();

    vt[0] = '{a: 8'hF0, b: 8'h3C, rnd: {80{1'b1}},
              ea: 24'hFFFFF0, eb: 24'hFFFF3C, z: 8'h30};
    vt[1] = '{a: 8'h00, b: 8'hFF, rnd: 80'h0,
              ea: 24'h000000, eb: 24'h0000FF, z: 8'h00};
    vt[2] = '{a: 8'hFF, b: 8'hFF, rnd: {48'h123456789ABC, 32'h44332211},
              ea: 24'h2211CC, eb: 24'h443388, z: 8'hFF};
    vt[3] = '{a: 8'hA5, b: 8'h5A, rnd: {48'hFEDCBA987654, 32'h0FF055AA},
              ea: 24'h55AA5A, eb: 24'h0FF0A5, z: 8'h00};

    // Reset state
    repeat (3) @(posedge clock_0);
    #1;
    chk("rst_enc_valid", enc_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_z", out_z, 8'h00);
    chk("rst_enc_a", enc_a, 24'h0);
    reset_0 = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Table-driven single operations with exact timing
    for (int v = 0; v < 4; v++) begin
      in_a = vt[v].a; in_b = vt[v].b; rnd_in = vt[v].rnd;
      in_valid = 1; rnd_valid = 1; out_ready = 1;
      @(posedge clock_0); #1;
      in_valid = 0; rnd_valid = 0;
      chk("tbl_enc_valid_t1", enc_valid, 1'b1);
      chk("tbl_enc_a", enc_a, vt[v].ea);
      chk("tbl_enc_b", enc_b, vt[v].eb);
      chk("tbl_enc_rand", enc_rand, vt[v].rnd[79:32]);
      chk("tbl_out_valid_t1", out_valid, 1'b0);
      @(posedge clock_0); #1;
      chk("tbl_enc_valid_t2", enc_valid, 1'b0);
      chk("tbl_enc_a_hold", enc_a, vt[v].ea);
      chk("tbl_out_valid_t2", out_valid, 1'b0);
      @(posedge clock_0); #1;
      chk("tbl_out_valid_t3", out_valid, 1'b1);
      chk("tbl_out_z", out_z, vt[v].z);
      @(posedge clock_0); #1;
      chk("tbl_out_valid_popped", out_valid, 1'b0);
    end
    exp_enc_a = vt[3].ea; exp_enc_b = vt[3].eb; exp_enc_rand = vt[3].rnd[79:32];

    // Back-to-back: 8 operations, sink always ready
    for (int i = 0; i < 8; i++)
      cycle(1, 1, 1, 8'($urandom), 8'($urandom), rand_rnd());
    idle(6, 1);

    // Backpressure: sink stalled, then drained
    for (int i = 0; i < 8; i++)
      cycle(1, 1, 0, 8'($urandom), 8'($urandom), rand_rnd());
    idle(3, 0);
    idle(8, 1);

    // No fresh randomness: operation waits
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 8'h5A, 8'hC3, rand_rnd());
    cycle(1, 1, 1, 8'h5A, 8'hC3, rand_rnd());
    idle(5, 1);

    // Simultaneous push/pop around count 3, pointers wrapping
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 8'($urandom), 8'($urandom), rand_rnd());
    idle(3, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 1, 8'($urandom), 8'($urandom), rand_rnd());
    idle(8, 1);

    // Reset mid-flight with one result buffered and one in the gadget
    cycle(1, 1, 0, 8'hEE, 8'h77, rand_rnd());
    cycle(1, 1, 0, 8'hBB, 8'hDD, rand_rnd());
    cycle(0, 0, 0, 8'h00, 8'h00, 80'h0);
    reset_0 = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_enc_valid", enc_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_out_z", out_z, 8'h00);
    chk("mid_rst_enc_b", enc_b, 24'h0);
    @(posedge clock_0); #1;
    reset_0 = 1'b0;
    model_reset();
    #1;
    chk("mid_rel_in_ready", in_ready, 1'b1);
    idle(6, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
            8'($urandom), 8'($urandom), rand_rnd());
    idle(10, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
